// File: rtl/risc_ctrl_pkg.sv
// risc_ctrl_pkg: shared types and encodings for the RISC control FSM.
//   state_e      - controller state enum
//   OPC_*/OP_*   - opcode / op field values used by DECODE dispatch
//   CND_*        - branch condition codes
//   NSEL/VSEL/MCMD/PCSEL_* - datapath select encodings
//   ctrl_out_t   - bundle of every controller output
//   decode_out() - Moore output decode for one state
package risc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET, S_IF1, S_IF2, S_UPD_PC, S_DECODE,
    S_MOV_IMM, S_MOV_R1, S_MOV_R2, S_MOV_R3,
    S_GET_A, S_GET_B, S_EXEC, S_EXEC_CMP, S_WB,
    S_ADDR_A, S_ADDR_C, S_ADDR_LD, S_MEM_RD, S_LDR_WB,
    S_STR_B, S_STR_C, S_MEM_WR,
    S_B_TAKE, S_BX, S_BL_LINK, S_BLX_LINK,
    S_HALT, S_FAULT
  } state_e;

  localparam logic [2:0] OPC_BR   = 3'b001;
  localparam logic [2:0] OPC_BX   = 3'b010;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_LDST    = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_BX      = 2'b00;
  localparam logic [1:0] OP_BLX     = 2'b10;
  localparam logic [1:0] OP_BL      = 2'b11;

  localparam logic [2:0] CND_AL = 3'b000;
  localparam logic [2:0] CND_EQ = 3'b001;
  localparam logic [2:0] CND_NE = 3'b010;
  localparam logic [2:0] CND_LT = 3'b011;
  localparam logic [2:0] CND_LE = 3'b100;

  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b001;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] MCMD_NONE  = 2'b00;
  localparam logic [1:0] MCMD_READ  = 2'b11;
  localparam logic [1:0] MCMD_WRITE = 2'b01;

  localparam logic [1:0] PCSEL_INC = 2'b00;
  localparam logic [1:0] PCSEL_REL = 2'b01;
  localparam logic [1:0] PCSEL_REG = 2'b10;

  typedef struct packed {
    logic       loada, loadb, loadc, loads, load_ir, load_pc, load_bpc, load_addr;
    logic       asel, bsel, addr_sel, reset_pc, write;
    logic [2:0] nsel;
    logic [1:0] vsel, mem_cmd, pc_sel;
    logic       w, fault, halted;
  } ctrl_out_t;

  function automatic ctrl_out_t decode_out(state_e s);
    ctrl_out_t o;
    o = '0;
    case (s)
      S_RESET:    begin o.reset_pc = 1'b1; o.load_pc = 1'b1; end
      S_IF1:      begin o.addr_sel = 1'b1; o.mem_cmd = MCMD_READ; end
      S_IF2:      begin o.addr_sel = 1'b1; o.mem_cmd = MCMD_READ; o.load_ir = 1'b1; end
      S_UPD_PC:   begin o.load_pc = 1'b1; o.pc_sel = PCSEL_INC; end
      S_DECODE:   o.nsel = NSEL_RN;
      S_MOV_IMM:  begin o.nsel = NSEL_RN; o.vsel = VSEL_IMM; o.write = 1'b1; end
      S_MOV_R1:   begin o.nsel = NSEL_RM; o.loadb = 1'b1; end
      S_MOV_R2:   begin o.asel = 1'b1; o.loadc = 1'b1; end
      S_MOV_R3:   begin o.nsel = NSEL_RD; o.vsel = VSEL_C; o.write = 1'b1; end
      S_GET_A:    begin o.nsel = NSEL_RN; o.loada = 1'b1; end
      S_GET_B:    begin o.nsel = NSEL_RM; o.loadb = 1'b1; end
      S_EXEC:     o.loadc = 1'b1;
      S_EXEC_CMP: o.loads = 1'b1;
      S_WB:       begin o.nsel = NSEL_RD; o.vsel = VSEL_C; o.write = 1'b1; end
      S_ADDR_A:   begin o.nsel = NSEL_RN; o.loada = 1'b1; end
      S_ADDR_C:   begin o.bsel = 1'b1; o.loadc = 1'b1; end
      S_ADDR_LD:  o.load_addr = 1'b1;
      S_MEM_RD:   o.mem_cmd = MCMD_READ;
      S_LDR_WB:   begin o.nsel = NSEL_RD; o.vsel = VSEL_MDATA; o.write = 1'b1; end
      S_STR_B:    begin o.nsel = NSEL_RD; o.loadb = 1'b1; end
      S_STR_C:    begin o.asel = 1'b1; o.loadc = 1'b1; end
      S_MEM_WR:   o.mem_cmd = MCMD_WRITE;
      S_B_TAKE:   begin o.load_pc = 1'b1; o.load_bpc = 1'b1; o.pc_sel = PCSEL_REL; end
      S_BX:       begin o.nsel = NSEL_RD; o.load_pc = 1'b1; o.load_bpc = 1'b1; o.pc_sel = PCSEL_REG; end
      S_BL_LINK,
      S_BLX_LINK: begin o.nsel = NSEL_RN; o.vsel = VSEL_PC; o.write = 1'b1; end
      S_HALT:     begin o.w = 1'b1; o.halted = 1'b1; end
      S_FAULT:    begin o.w = 1'b1; o.fault = 1'b1; end
      default:    ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/risc_ctrl_fsm_if.sv
// risc_ctrl_fsm_if: controller <-> datapath/memory bundle.
//   inputs to controller : opcode/op/cond (IR fields), flag_n/v/z, mem_rdy
//   outputs of controller: datapath strobes/selects, mem_cmd, w/fault/halted
//   master = controller side, slave = datapath side
interface risc_ctrl_fsm_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] cond;
  logic       flag_n, flag_v, flag_z, mem_rdy;
  logic       loada, loadb, loadc, loads, load_ir, load_pc, load_bpc, load_addr;
  logic       asel, bsel, addr_sel, reset_pc, write;
  logic [2:0] nsel;
  logic [1:0] vsel, mem_cmd, pc_sel;
  logic       w, fault, halted;

  modport master (
    input  opcode, op, cond, flag_n, flag_v, flag_z, mem_rdy,
    output loada, loadb, loadc, loads, load_ir, load_pc, load_bpc, load_addr,
           asel, bsel, addr_sel, reset_pc, write, nsel, vsel, mem_cmd, pc_sel,
           w, fault, halted
  );

  modport slave (
    output opcode, op, cond, flag_n, flag_v, flag_z, mem_rdy,
    input  loada, loadb, loadc, loads, load_ir, load_pc, load_bpc, load_addr,
           asel, bsel, addr_sel, reset_pc, write, nsel, vsel, mem_cmd, pc_sel,
           w, fault, halted
  );
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled cycles inside a memory wait state.
//   clk, reset  - clock, async active-high reset
//   clr_i       - hold count at 0 (asserted outside wait states)
//   stall_i     - this cycle is a stalled wait cycle
//   expire_o    - this stalled cycle is the MAX_WAIT-th one; leave for FAULT
// MAX_WAIT = 0 disables expiry.
module mem_wait_timer #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic stall_i,
  output logic expire_o
);
  localparam int W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int LAST = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;

  logic [W-1:0] cnt_q, cnt_d;

  // Count saturates at MAX_WAIT so it never wraps back into range.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (stall_i && cnt_q != W'(MAX_WAIT))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  // The count holds the number of earlier stalled cycles, so the
  // MAX_WAIT-th stall is the one seen with count MAX_WAIT-1.
  assign expire_o = (MAX_WAIT > 0) && stall_i && (cnt_q == W'(LAST));
endmodule

// File: rtl/risc_ctrl_fsm.sv
// risc_ctrl_fsm: multi-cycle Moore controller for the RISC datapath.
//   clk    - rising-edge clock
//   reset  - async active-high, forces RESET
//   bus    - risc_ctrl_fsm_if.master: IR fields, flags, mem_rdy in;
//            datapath strobes/selects, mem_cmd, w/fault/halted out
// Outputs are registered alongside the state: out_q always equals the
// decode of state_q, so they depend on the registered state only.
module risc_ctrl_fsm #(
  parameter int MAX_WAIT        = 8,
  parameter int HALT_ON_ILLEGAL = 1,
  parameter int COND_BR_EN      = 1
) (
  input  logic            clk,
  input  logic            reset,
  risc_ctrl_fsm_if.master bus
);
  import risc_ctrl_pkg::*;

  localparam state_e S_ILL = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_IF1;

  state_e    state_q, state_d;
  ctrl_out_t out_q;
  logic      in_wait, stalled, expire, cond_ok, cond_bad;

  assign in_wait = (state_q == S_IF2) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign stalled = in_wait && !bus.mem_rdy;

  // Cleared whenever we are outside a wait state, so every entry starts at 0.
  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (!in_wait),
    .stall_i  (stalled),
    .expire_o (expire)
  );

  always_comb begin
    cond_ok  = 1'b0;
    cond_bad = 1'b0;
    case (bus.cond)
      CND_AL:  cond_ok = 1'b1;
      CND_EQ:  cond_ok = bus.flag_z;
      CND_NE:  cond_ok = !bus.flag_z;
      CND_LT:  cond_ok = bus.flag_n ^ bus.flag_v;
      CND_LE:  cond_ok = (bus.flag_n ^ bus.flag_v) | bus.flag_z;
      default: cond_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:    state_d = S_IF1;
      S_IF1:      state_d = S_IF2;
      S_IF2:      state_d = bus.mem_rdy ? S_UPD_PC : (expire ? S_FAULT : S_IF2);
      S_UPD_PC:   state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OPC_MOV:  state_d = (bus.op == OP_MOV_IMM) ? S_MOV_IMM : S_MOV_R1;
          OPC_ALU:  state_d = (bus.op == OP_MVN) ? S_GET_B : S_GET_A;
          OPC_LDR,
          OPC_STR:  state_d = (bus.op == OP_LDST) ? S_ADDR_A : S_ILL;
          OPC_BR: begin
            if (COND_BR_EN == 0) state_d = S_B_TAKE;
            else if (cond_bad)   state_d = S_ILL;
            else                 state_d = cond_ok ? S_B_TAKE : S_IF1;
          end
          OPC_BX: begin
            case (bus.op)
              OP_BL:   state_d = S_BL_LINK;
              OP_BX:   state_d = S_BX;
              OP_BLX:  state_d = S_BLX_LINK;
              default: state_d = S_ILL;
            endcase
          end
          OPC_HALT: state_d = S_HALT;
          default:  state_d = S_ILL;
        endcase
      end
      S_MOV_IMM:  state_d = S_IF1;
      S_MOV_R1:   state_d = S_MOV_R2;
      S_MOV_R2:   state_d = S_MOV_R3;
      S_MOV_R3:   state_d = S_IF1;
      S_GET_A:    state_d = S_GET_B;
      // CMP gets its own EXEC flavour so loads stays a pure state decode.
      S_GET_B:    state_d = (bus.op == OP_CMP) ? S_EXEC_CMP : S_EXEC;
      S_EXEC:     state_d = S_WB;
      S_EXEC_CMP: state_d = S_IF1;
      S_WB:       state_d = S_IF1;
      S_ADDR_A:   state_d = S_ADDR_C;
      S_ADDR_C:   state_d = S_ADDR_LD;
      S_ADDR_LD:  state_d = (bus.opcode == OPC_STR) ? S_STR_B : S_MEM_RD;
      S_MEM_RD:   state_d = bus.mem_rdy ? S_LDR_WB : (expire ? S_FAULT : S_MEM_RD);
      S_LDR_WB:   state_d = S_IF1;
      S_STR_B:    state_d = S_STR_C;
      S_STR_C:    state_d = S_MEM_WR;
      S_MEM_WR:   state_d = bus.mem_rdy ? S_IF1 : (expire ? S_FAULT : S_MEM_WR);
      S_B_TAKE:   state_d = S_IF1;
      S_BX:       state_d = S_IF1;
      S_BL_LINK:  state_d = S_B_TAKE;
      S_BLX_LINK: state_d = S_BX;
      S_HALT:     state_d = S_HALT;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_RESET;
      out_q   <= decode_out(S_RESET);
    end else begin
      state_q <= state_d;
      out_q   <= decode_out(state_d);
    end

  assign bus.loada     = out_q.loada;
  assign bus.loadb     = out_q.loadb;
  assign bus.loadc     = out_q.loadc;
  assign bus.loads     = out_q.loads;
  assign bus.load_ir   = out_q.load_ir;
  assign bus.load_pc   = out_q.load_pc;
  assign bus.load_bpc  = out_q.load_bpc;
  assign bus.load_addr = out_q.load_addr;
  assign bus.asel      = out_q.asel;
  assign bus.bsel      = out_q.bsel;
  assign bus.addr_sel  = out_q.addr_sel;
  assign bus.reset_pc  = out_q.reset_pc;
  assign bus.write     = out_q.write;
  assign bus.nsel      = out_q.nsel;
  assign bus.vsel      = out_q.vsel;
  assign bus.mem_cmd   = out_q.mem_cmd;
  assign bus.pc_sel    = out_q.pc_sel;
  assign bus.w         = out_q.w;
  assign bus.fault     = out_q.fault;
  assign bus.halted    = out_q.halted;
endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// tb_risc_ctrl_fsm: two controllers share stimulus; dut_a uses default
// parameters, dut_b uses MAX_WAIT=4, HALT_ON_ILLEGAL=0, COND_BR_EN=0.
// Each instruction is expanded into the list of output vectors the
// instruction set rules call for; the bench walks that list cycle by
// cycle, repeating wait steps while mem_rdy is low.
module tb_risc_ctrl_fsm;
  typedef logic [24:0] ov_t;

  localparam ov_t LA    = ov_t'(1) << 24;
  localparam ov_t LB    = ov_t'(1) << 23;
  localparam ov_t LC    = ov_t'(1) << 22;
  localparam ov_t LS    = ov_t'(1) << 21;
  localparam ov_t LIR   = ov_t'(1) << 20;
  localparam ov_t LPC   = ov_t'(1) << 19;
  localparam ov_t LBPC  = ov_t'(1) << 18;
  localparam ov_t LADDR = ov_t'(1) << 17;
  localparam ov_t AS    = ov_t'(1) << 16;
  localparam ov_t BS    = ov_t'(1) << 15;
  localparam ov_t ADS   = ov_t'(1) << 14;
  localparam ov_t RPC   = ov_t'(1) << 13;
  localparam ov_t WR    = ov_t'(1) << 12;
  localparam ov_t N_RN  = ov_t'(4) << 9;
  localparam ov_t N_RD  = ov_t'(2) << 9;
  localparam ov_t N_RM  = ov_t'(1) << 9;
  localparam ov_t V_PC  = ov_t'(1) << 7;
  localparam ov_t V_IMM = ov_t'(2) << 7;
  localparam ov_t V_MD  = ov_t'(3) << 7;
  localparam ov_t M_RD  = ov_t'(3) << 5;
  localparam ov_t M_WR  = ov_t'(1) << 5;
  localparam ov_t P_REL = ov_t'(1) << 3;
  localparam ov_t P_REG = ov_t'(2) << 3;
  localparam ov_t W     = ov_t'(4);
  localparam ov_t FLT   = ov_t'(2);
  localparam ov_t HLT   = ov_t'(1);

  typedef struct {
    string nm;
    ov_t   v;
    bit    wt;
  } step_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode, cond;
  logic [1:0] op;
  logic       fn, fv, fz, mem_rdy;
  bit         sel;
  int         n_vec, n_bad;
  int         m_mw;
  bit         m_hoi, m_cbe;
  step_t      q[$];

  always #5 clk = ~clk;

  risc_ctrl_fsm_if bus_a();
  risc_ctrl_fsm_if bus_b();

  assign bus_a.opcode = opcode;  assign bus_b.opcode = opcode;
  assign bus_a.op     = op;      assign bus_b.op     = op;
  assign bus_a.cond   = cond;    assign bus_b.cond   = cond;
  assign bus_a.flag_n = fn;      assign bus_b.flag_n = fn;
  assign bus_a.flag_v = fv;      assign bus_b.flag_v = fv;
  assign bus_a.flag_z = fz;      assign bus_b.flag_z = fz;
  assign bus_a.mem_rdy = mem_rdy; assign bus_b.mem_rdy = mem_rdy;

  risc_ctrl_fsm dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  risc_ctrl_fsm #(.MAX_WAIT(4), .HALT_ON_ILLEGAL(0), .COND_BR_EN(0))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  ov_t obs_a, obs_b;
  assign obs_a = {bus_a.loada, bus_a.loadb, bus_a.loadc, bus_a.loads, bus_a.load_ir,
                  bus_a.load_pc, bus_a.load_bpc, bus_a.load_addr, bus_a.asel, bus_a.bsel,
                  bus_a.addr_sel, bus_a.reset_pc, bus_a.write, bus_a.nsel, bus_a.vsel,
                  bus_a.mem_cmd, bus_a.pc_sel, bus_a.w, bus_a.fault, bus_a.halted};
  assign obs_b = {bus_b.loada, bus_b.loadb, bus_b.loadc, bus_b.loads, bus_b.load_ir,
                  bus_b.load_pc, bus_b.load_bpc, bus_b.load_addr, bus_b.asel, bus_b.bsel,
                  bus_b.addr_sel, bus_b.reset_pc, bus_b.write, bus_b.nsel, bus_b.vsel,
                  bus_b.mem_cmd, bus_b.pc_sel, bus_b.w, bus_b.fault, bus_b.halted};

  function automatic ov_t obs();
    return sel ? obs_b : obs_a;
  endfunction

  task automatic chk(input string tag, input ov_t got, input ov_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut=%s got=%h want=%h t=%0t", tag, sel ? "b" : "a", got, exp, $time);
    end
  endtask

  task automatic push(input string nm, input ov_t v, input bit wt);
    step_t s;
    s.nm = nm; s.v = v; s.wt = wt;
    q.push_back(s);
  endtask

  // Called at posedge+1; checks reset outputs, releases after two edges.
  task automatic assert_reset();
    reset = 1'b1;
    #1 chk("RESET", obs(), RPC | LPC);
    repeat (2) begin
      @(posedge clk); #1;
      chk("RESET", obs(), RPC | LPC);
    end
    reset = 1'b0;
  endtask

  // Expand one instruction into its expected output sequence.
  task automatic plan(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c,
                      input logic [2:0] nvz, output bit halt_end);
    bit n, v, z, lt, take, ill;
    {n, v, z} = nvz;
    lt = (n != v);
    take = 1'b0; ill = 1'b0; halt_end = 1'b0;
    q.delete();
    push("IF1", ADS | M_RD, 0);
    push("IF2", ADS | M_RD | LIR, 1);
    push("UPD_PC", LPC, 0);
    push("DECODE", N_RN, 0);
    case (opc)
      3'd6: if (o == 2'd2) push("MOV_IMM", N_RN | V_IMM | WR, 0);
            else begin
              push("MOV_R1", N_RM | LB, 0);
              push("MOV_R2", AS | LC, 0);
              push("MOV_R3", N_RD | WR, 0);
            end
      3'd5: begin
        if (o != 2'd3) push("GET_A", N_RN | LA, 0);
        push("GET_B", N_RM | LB, 0);
        if (o == 2'd1) push("EXEC_CMP", LS, 0);
        else begin
          push("EXEC", LC, 0);
          push("WB", N_RD | WR, 0);
        end
      end
      3'd3, 3'd4: if (o != 2'd0) ill = 1'b1;
      else begin
        push("ADDR_A", N_RN | LA, 0);
        push("ADDR_C", BS | LC, 0);
        push("ADDR_LD", LADDR, 0);
        if (opc == 3'd3) begin
          push("MEM_RD", M_RD, 1);
          push("LDR_WB", N_RD | V_MD | WR, 0);
        end else begin
          push("STR_B", N_RD | LB, 0);
          push("STR_C", AS | LC, 0);
          push("MEM_WR", M_WR, 1);
        end
      end
      3'd1: begin
        case (c)
          3'd0: take = 1'b1;
          3'd1: take = z;
          3'd2: take = !z;
          3'd3: take = lt;
          3'd4: take = lt || z;
          default: ill = 1'b1;
        endcase
        if (!m_cbe) begin take = 1'b1; ill = 1'b0; end
        if (take && !ill) push("B_TAKE", LPC | LBPC | P_REL, 0);
      end
      3'd2: case (o)
        2'd3: begin
          push("BL_LINK", N_RN | V_PC | WR, 0);
          push("B_TAKE", LPC | LBPC | P_REL, 0);
        end
        2'd0: push("BX", N_RD | LPC | LBPC | P_REG, 0);
        2'd2: begin
          push("BLX_LINK", N_RN | V_PC | WR, 0);
          push("BX", N_RD | LPC | LBPC | P_REG, 0);
        end
        default: ill = 1'b1;
      endcase
      3'd7: halt_end = 1'b1;
      default: ill = 1'b1;
    endcase
    if (ill && m_hoi) halt_end = 1'b1;
  endtask

  // st_idx < 0: random mem_rdy (at most 3 stalls in a row).
  // st_idx >= 0: the wait step at that index stalls st_n cycles, others ready.
  // abort_at >= 0: assert reset right after checking that step.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c,
                           input logic [2:0] nvz, input int st_idx, input int st_n,
                           input int abort_at);
    bit halt_end, first, rdy;
    int stall, idx;
    plan(opc, o, c, nvz, halt_end);
    first = 1'b1; stall = 0; idx = 0;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      chk(q[0].nm, obs(), q[0].v);
      if (first) begin
        opcode = opc; op = o; cond = c; {fn, fv, fz} = nvz;
        first = 1'b0;
      end
      if (idx == abort_at) begin
        assert_reset();
        return;
      end
      if (st_idx < 0) rdy = !(stall < 3 && $urandom_range(0, 99) < 35);
      else            rdy = (idx != st_idx) || (stall >= st_n);
      mem_rdy = rdy;
      if (q[0].wt && !rdy) begin
        stall++;
        if (m_mw > 0 && stall == m_mw) begin
          repeat (3) begin
            @(posedge clk); #1;
            chk("FAULT", obs(), W | FLT);
          end
          mem_rdy = 1'b1;
          assert_reset();
          return;
        end
      end else begin
        stall = 0;
        void'(q.pop_front());
        idx++;
      end
    end
    if (halt_end) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("HALT", obs(), W | HLT);
      end
      assert_reset();
    end
  endtask

  task automatic run_random(input int n);
    logic [2:0] ro, rc, rf;
    logic [1:0] rp;
    for (int i = 0; i < n; i++) begin
      ro = 3'($urandom_range(0, 7));
      rp = 2'($urandom_range(0, 3));
      rc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      rf = 3'($urandom_range(0, 7));
      run_instr(ro, rp, rc, rf, -1, 0, -1);
    end
  endtask

  initial begin
    reset = 1'b1; mem_rdy = 1'b1;
    opcode = '0; op = '0; cond = '0; fn = 1'b0; fv = 1'b0; fz = 1'b0;
    n_vec = 0; n_bad = 0; sel = 1'b0;
    m_mw = 8; m_hoi = 1'b1; m_cbe = 1'b1;
    @(posedge clk); #1;
    assert_reset();

    // dut_a directed
    run_instr(3'b110, 2'b10, 3'b000, 3'b000, 99, 0, -1);  // MOV R0,#5
    run_instr(3'b110, 2'b10, 3'b000, 3'b000, 1, 3, -1);   // 3 stalls in IF2
    run_instr(3'b110, 2'b00, 3'b000, 3'b000, 99, 0, -1);  // MOV reg
    run_instr(3'b101, 2'b00, 3'b000, 3'b000, 99, 0, -1);  // ADD
    run_instr(3'b101, 2'b01, 3'b000, 3'b000, 99, 0, -1);  // CMP
    run_instr(3'b101, 2'b11, 3'b000, 3'b000, 99, 0, -1);  // MVN
    run_instr(3'b011, 2'b00, 3'b000, 3'b000, 7, 2, -1);   // LDR, 2 stalls
    run_instr(3'b100, 2'b00, 3'b000, 3'b000, 9, 2, -1);   // STR, 2 stalls
    run_instr(3'b001, 2'b00, 3'b001, 3'b000, 99, 0, -1);  // BEQ, Z=0
    run_instr(3'b001, 2'b00, 3'b011, 3'b100, 99, 0, -1);  // BLT, N=1 V=0
    run_instr(3'b001, 2'b00, 3'b100, 3'b001, 99, 0, -1);  // BLE, Z=1
    run_instr(3'b010, 2'b11, 3'b000, 3'b000, 99, 0, -1);  // BL
    run_instr(3'b010, 2'b00, 3'b000, 3'b000, 99, 0, -1);  // BX
    run_instr(3'b010, 2'b10, 3'b000, 3'b000, 99, 0, -1);  // BLX
    run_instr(3'b000, 2'b00, 3'b000, 3'b000, 99, 0, -1);  // illegal -> HALT
    run_instr(3'b001, 2'b00, 3'b110, 3'b000, 99, 0, -1);  // bad cond -> HALT
    run_instr(3'b111, 2'b00, 3'b000, 3'b000, 99, 0, -1);  // HALT
    run_instr(3'b100, 2'b00, 3'b000, 3'b000, 99, 0, 8);   // reset in STR_C
    run_instr(3'b011, 2'b00, 3'b000, 3'b000, 7, 1000, -1); // FAULT at 8
    run_random(250);

    // dut_b: MAX_WAIT=4, illegal skipped, branches unconditional
    sel = 1'b1; m_mw = 4; m_hoi = 1'b0; m_cbe = 1'b0;
    @(posedge clk); #1;
    assert_reset();
    run_instr(3'b011, 2'b00, 3'b000, 3'b000, 7, 1000, -1); // FAULT at 4
    run_instr(3'b000, 2'b00, 3'b000, 3'b000, 99, 0, -1);   // illegal -> IF1
    run_instr(3'b010, 2'b01, 3'b000, 3'b000, 99, 0, -1);   // illegal -> IF1
    run_instr(3'b001, 2'b00, 3'b001, 3'b000, 99, 0, -1);   // BEQ Z=0 taken
    run_instr(3'b100, 2'b00, 3'b000, 3'b000, 9, 3, -1);    // STR, 3 stalls
    run_random(150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/risc_ctrl_fsm.md
RISC_CTRL_FSM -- requirements
Module: risc_ctrl_fsm

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 8: memory-stall cycles before FAULT; 0 disables the timeout.
REQ-002 SHALL have parameter HALT_ON_ILLEGAL, default 1: 1 sends illegal encodings to HALT, 0 skips them (DECODE->IF1).
REQ-003 SHALL have parameter COND_BR_EN, default 1: 1 evaluates cond for opcode 001, 0 treats every 001 as unconditional.
REQ-004 clk  in  1  clock, rising edge; reset  in  1  reset, asynchronous, active-high.
REQ-005 opcode in 3, op in 2, cond in 3: instruction fields from IR.
REQ-006 flag_n, flag_v, flag_z  in  1 each  status flags.
REQ-007 mem_rdy  in  1  memory completes the current read or write when 1.
REQ-008 loada, loadb, loadc, loads, load_ir, load_pc, load_bpc, load_addr, asel, bsel, addr_sel, reset_pc, write  out  1 each  datapath strobes and selects.
REQ-009 nsel out 3 one-hot (100 Rn, 010 Rd, 001 Rm); vsel out 2 (00 C, 01 PC, 10 sximm8, 11 mdata); mem_cmd out 2 (00 none, 11 read, 01 write); pc_sel out 2 (00 PC+1, 01 PC+1+sximm8, 10 R[Rd]).
REQ-010 w, fault, halted  out  1 each  status.

Function
REQ-011 SHALL be a Moore machine: every output decoded from the registered state only; unlisted outputs are 0.
REQ-012 SHALL implement the fetch sequence RESET->IF1->IF2->UPD_PC->DECODE.
- RESET: reset_pc, load_pc.
- IF1: addr_sel, mem_cmd=11.
- IF2: same outputs as IF1 plus load_ir.
- UPD_PC: load_pc, pc_sel=00.
- DECODE: nsel=Rn.
REQ-013 IF2, MEM_RD and MEM_WR SHALL hold their state and outputs while mem_rdy=0 and advance on the first clk edge with mem_rdy=1.
REQ-014 Stall timer: reset to 0 on entry to any wait state; incremented per stalled cycle. When it reaches MAX_WAIT (MAX_WAIT>0) with mem_rdy=0, the next state SHALL be FAULT.
REQ-015 DECODE dispatch:
- 110/op10 -> MOV_IMM.
- 110/other op -> MOV_R1.
- 101 -> GET_A, except op11 -> GET_B.
- 011/00 -> LDR.
- 100/00 -> STR.
- 001 -> B_TAKE if the condition holds, else IF1.
- 010/11 -> BL_LINK.
- 010/00 -> BX.
- 010/10 -> BLX_LINK.
- 111 -> HALT.
- anything else -> per HALT_ON_ILLEGAL.
REQ-016 Branch conditions: 000 always; 001 Z; 010 !Z; 011 N!=V; 100 (N!=V)|Z; 101-111 illegal.
REQ-017 MOV_IMM: nsel=Rn, vsel=10, write; then IF1.
REQ-018 MOV sequence:
- MOV_R1: nsel=Rm, loadb.
- MOV_R2: asel, loadc.
- MOV_R3: nsel=Rd, vsel=00, write; then IF1.
REQ-019 ALU sequence:
- GET_A: nsel=Rn, loada.
- GET_B: nsel=Rm, loadb.
- EXEC: loadc; CMP (op01) asserts loads instead and goes to IF1.
- WB: nsel=Rd, vsel=00, write.
REQ-020 LDR sequence:
- ADDR_A: nsel=Rn, loada.
- ADDR_C: bsel, loadc.
- ADDR_LD: load_addr.
- MEM_RD: mem_cmd=11.
- LDR_WB: nsel=Rd, vsel=11, write.
REQ-021 STR sequence:
- ADDR_A, ADDR_C, ADDR_LD as for LDR.
- STR_B: nsel=Rd, loadb.
- STR_C: asel, loadc.
- MEM_WR: mem_cmd=01; then IF1.
REQ-022 Branch states:
- B_TAKE: load_pc, load_bpc, pc_sel=01.
- BX: nsel=Rd, load_pc, load_bpc, pc_sel=10.
- BL_LINK: nsel=Rn, vsel=01, write; then B_TAKE.
- BLX_LINK: nsel=Rn, vsel=01, write; then BX.
- All of B_TAKE and BX return to IF1.
REQ-023 HALT: w=1, halted=1, self-loop.
REQ-024 FAULT: w=1, fault=1, self-loop; both exit only via reset.
REQ-025 Any unreachable state encoding SHALL go to RESET on the next edge.

Reset
REQ-026 reset asserted SHALL force state RESET immediately, including mid-stall or mid-instruction, and clear the stall timer.
REQ-027 During reset, outputs: reset_pc=1, load_pc=1, all others 0 (w, fault, halted, mem_cmd=00).
REQ-028 The first edge after deassertion SHALL enter IF1.

Structure
REQ-029 Package risc_ctrl_pkg SHALL hold the state enum, opcode/op constants, cond codes, and the nsel/vsel/mem_cmd/pc_sel encodings.
REQ-030 The stall timer SHALL be sub-module mem_wait_timer, parameterised by MAX_WAIT, with width $clog2(MAX_WAIT+1) (minimum 1).

Verification
REQ-031 mem_rdy=1, MOV R0,#5 (110/10): IF1..MOV_IMM = 5 cycles with write=1, vsel=10, nsel=100; back in IF1 on cycle 6.
REQ-032 mem_rdy low 3 cycles in IF2 (MAX_WAIT=8): IF2 held 4 cycles, load_ir high throughout, no FAULT.
REQ-033 mem_rdy stuck 0 in MEM_RD with MAX_WAIT=4: FAULT after 4 stalled cycles; fault=1 until reset.
REQ-034 BEQ with Z=0 -> IF1 with no load_pc pulse. BLT with N=1, V=0 -> B_TAKE with pc_sel=01.
REQ-035 BLX (010/10): BLX_LINK (vsel=01, write), then BX (pc_sel=10, nsel=010), then IF1.
REQ-036 Opcode 000: HALT when HALT_ON_ILLEGAL=1, IF1 when 0. reset asserted mid-STR (STR_C) -> RESET that cycle, mem_cmd=00.
